// File: rtl/ahb_lite_mem_ws_pkg.sv
// Shared AHB-Lite codes, FSM states and byte-enable helper
// for the wait-state bus memory.
package ahb_lite_mem_ws_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_X8  = 3'd0;
    localparam logic [2:0] HSIZE_X16 = 3'd1;
    localparam logic [2:0] HSIZE_X32 = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic [3:0] byte_en(
        input logic [2:0] size,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'h0;
        unique case (1'b1)
            (size == HSIZE_X8):  be = 4'b0001 << a;
            (size == HSIZE_X16): be = a[1] ? 4'b1100 : 4'b0011;
            (size == HSIZE_X32): be = 4'hF;
            default:             be = 4'h0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_ws_if.sv
// AHB-Lite single-slave bus bundle between a master
// and the wait-state memory.
interface ahb_lite_mem_ws_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HBURST, HSIZE,
        output HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HBURST, HSIZE,
        input  HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_mem_ws_ram_be.sv
// Single-port word RAM with byte enables, registered read
// and per-lane forwarding of a same-edge write.
module ahb_ram_be #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i] && waddr == raddr)
                    rdata[8*i +: 8] <= wdata[8*i +: 8];
                else
                    rdata[8*i +: 8] <= mem[raddr][8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/ahb_lite_mem_ws.sv
// AHB-Lite memory slave with programmable NONSEQ/SEQ wait
// states, sub-word writes and two-cycle ERROR responses.
module ahb_lite_mem_ws
    import ahb_lite_mem_ws_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int WAIT_STATES     = 2,
    parameter int SEQ_WAIT_STATES = 0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_lite_mem_ws_if.slave bus
);
    localparam int BW = ADDR_WIDTH + 2;

    state_e          state;
    logic [3:0]      cnt;
    logic            hready_q;
    logic            hresp_q;
    logic            dp_act;
    logic            dp_write;
    logic [2:0]      dp_size;
    logic [BW-1:0]   dp_addr;

    logic            accept;
    logic            illegal;
    logic [3:0]      ws;
    logic [3:0]      we;
    logic            re;
    logic [ADDR_WIDTH-1:0] raddr;

    assign accept = hready_q && bus.HSEL && bus.HTRANS[1];

    assign ws = (bus.HTRANS == HTRANS_SEQ) ? 4'(SEQ_WAIT_STATES)
                                           : 4'(WAIT_STATES);

    assign illegal = (|(bus.HADDR >> BW))
                  || (bus.HSIZE > HSIZE_X32)
                  || (bus.HSIZE == HSIZE_X16 && bus.HADDR[0])
                  || (bus.HSIZE == HSIZE_X32 && bus.HADDR[1:0] != 2'b00);

    // Writes land on the edge closing the data phase.
    assign we = (hready_q && dp_act && dp_write && !HRESET)
              ? byte_en(dp_size, dp_addr[1:0]) : 4'h0;

    // Read is issued one edge before HREADY rises.
    assign re = !HRESET
             && ((accept && !illegal && !bus.HWRITE && ws == 4'd0)
              || (state == ST_WAIT && cnt == 4'd1 && !dp_write));

    assign raddr = (state == ST_WAIT) ? dp_addr[BW-1:2]
                                      : bus.HADDR[BW-1:2];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            dp_act   <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= 3'd0;
            dp_addr  <= '0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    dp_act   <= 1'b0;
                    if (accept) begin
                        dp_write <= bus.HWRITE;
                        dp_size  <= bus.HSIZE;
                        dp_addr  <= bus.HADDR[BW-1:0];
                        if (illegal) begin
                            state    <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else begin
                            dp_act <= 1'b1;
                            if (ws != 4'd0) begin
                                state    <= ST_WAIT;
                                cnt      <= ws;
                                hready_q <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.HREADY = hready_q;
    assign bus.HRESP  = hresp_q;

    ahb_ram_be #(
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk   (HCLK),
        .rst   (HRESET),
        .re    (re),
        .raddr (raddr),
        .we    (we),
        .waddr (dp_addr[BW-1:2]),
        .wdata (bus.HWDATA),
        .rdata (bus.HRDATA)
    );
endmodule

// File: tb/tb_ahb_lite_mem_ws.sv
// Directed bench for ahb_lite_mem_ws: wait states, sub-word
// writes, bursts, errors, reset abort and forwarding.
module tb_ahb_lite_mem_ws;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;

    ahb_lite_mem_ws_if bus();
    ahb_lite_mem_ws_if bus0();

    ahb_lite_mem_ws #(
        .ADDR_WIDTH(10), .WAIT_STATES(2), .SEQ_WAIT_STATES(0)
    ) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );

    ahb_lite_mem_ws #(
        .ADDR_WIDTH(10), .WAIT_STATES(0), .SEQ_WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus0)
    );

    always #5 HCLK = ~HCLK;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
        bus.HADDR  = 32'h0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd2;
        bus.HBURST = 3'd0;
    endtask

    task automatic present(input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [1:0] tr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = tr;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HBURST = 3'd0;
    endtask

    // Counts HREADY-low cycles until HREADY rises (bounded).
    task automatic wait_ready(output int waits);
        waits = 0;
        @(negedge HCLK);
        while (!bus.HREADY && waits < 40) begin
            waits++;
            @(negedge HCLK);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output int waits, output logic [31:0] rdata,
                        output logic r1, output logic r2);
        present(wr, addr, size, 2'd2);
        @(posedge HCLK); #1;
        bus_idle();
        bus.HADDR  = 32'hFFFF_FFFC;
        bus.HWDATA = wdata;
        waits = 0;
        @(negedge HCLK);
        r1 = bus.HRESP;
        while (!bus.HREADY && waits < 40) begin
            waits++;
            @(negedge HCLK);
        end
        rdata = bus.HRDATA;
        r2 = bus.HRESP;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] d);
        int w; logic [31:0] rd; logic r1, r2;
        xfer(1'b1, addr, size, d, w, rd, r1, r2);
        chk({tag, "_ws"}, w, 2);
        chk({tag, "_resp"}, r2, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp);
        int w; logic [31:0] d; logic r1, r2;
        xfer(1'b0, addr, 3'd2, 32'h0, w, d, r1, r2);
        chk({tag, "_ws"}, w, 2);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_resp"}, r2, 0);
    endtask

    task automatic err(input string tag, input logic w_r,
                       input logic [31:0] addr, input logic [2:0] size);
        int w; logic [31:0] d; logic r1, r2;
        xfer(w_r, addr, size, 32'hDEAD_DEAD, w, d, r1, r2);
        chk({tag, "_ws"}, w, 1);
        chk({tag, "_resp1"}, r1, 1);
        chk({tag, "_resp2"}, r2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus_idle();
        bus.HWDATA  = 32'h0;
        bus0.HSEL   = 1'b0;
        bus0.HTRANS = 2'd0;
        bus0.HADDR  = 32'h0;
        bus0.HWRITE = 1'b0;
        bus0.HSIZE  = 3'd2;
        bus0.HBURST = 3'd0;
        bus0.HWDATA = 32'h0;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_hready", bus.HREADY, 1);
        chk("rst_hresp", bus.HRESP, 0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_hrdata0", bus0.HRDATA, 32'h0);
        @(posedge HCLK); #1;

        wr("w8", 32'h8, 3'd2, 32'h7654_3210);
        rd("r8", 32'h8, 32'h7654_3210);
        wr("wb9", 32'h9, 3'd0, 32'h0000_AA00);
        rd("r8b", 32'h8, 32'h7654_AA10);
        wr("whA", 32'hA, 3'd1, 32'hBEEF_0000);
        rd("r8h", 32'h8, 32'hBEEF_AA10);

        for (int i = 0; i < 4; i++)
            wr("pre", 32'h10 + 4*i, 3'd2, 32'(i + 1));
        present(1'b0, 32'h10, 3'd2, 2'd2);
        bus.HBURST = 3'd3;
        @(posedge HCLK); #1;
        for (int b = 1; b <= 4; b++) begin
            if (b < 4) begin
                present(1'b0, 32'h10 + 4*b, 3'd2, 2'd3);
                bus.HBURST = 3'd3;
            end else begin
                bus_idle();
            end
            wait_ready(n);
            chk($sformatf("burst_ws%0d", b), n, (b == 1) ? 2 : 0);
            chk($sformatf("burst_d%0d", b), bus.HRDATA, 32'(b));
            @(posedge HCLK); #1;
        end

        wr("w0", 32'h0, 3'd2, 32'h1122_3344);
        err("e_range", 1'b1, 32'h1000, 3'd2);
        rd("r0", 32'h0, 32'h1122_3344);
        err("e_size3", 1'b0, 32'h0, 3'd3);
        err("e_align", 1'b0, 32'h2, 3'd2);

        present(1'b1, 32'h1000, 3'd2, 2'd2);
        @(posedge HCLK); #1;
        bus_idle();
        bus.HWDATA = 32'hDEAD_DEAD;
        @(negedge HCLK);
        chk("err1_hready", bus.HREADY, 0);
        chk("err1_hresp", bus.HRESP, 1);
        @(posedge HCLK); #1;
        present(1'b0, 32'h8, 3'd2, 2'd2);
        @(negedge HCLK);
        chk("err2_hready", bus.HREADY, 1);
        chk("err2_hresp", bus.HRESP, 1);
        @(posedge HCLK); #1;
        bus_idle();
        wait_ready(n);
        chk("after_err_ws", n, 2);
        chk("after_err_data", bus.HRDATA, 32'hBEEF_AA10);
        chk("after_err_resp", bus.HRESP, 0);
        @(posedge HCLK); #1;

        wr("w20", 32'h20, 3'd2, 32'hA5A5_A5A5);
        present(1'b1, 32'h20, 3'd2, 2'd2);
        @(posedge HCLK); #1;
        bus_idle();
        bus.HWDATA = 32'h1234_5678;
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("abort_wait", bus.HREADY, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("abort_hready", bus.HREADY, 1);
        chk("abort_hresp", bus.HRESP, 0);
        chk("abort_hrdata", bus.HRDATA, 32'h0);
        @(posedge HCLK); #1;
        rd("r20", 32'h20, 32'hA5A5_A5A5);

        present(1'b0, 32'h8, 3'd2, 2'd1);
        @(posedge HCLK); #1;
        present(1'b0, 32'h8, 3'd2, 2'd0);
        @(negedge HCLK);
        chk("busy_hready", bus.HREADY, 1);
        chk("busy_hresp", bus.HRESP, 0);
        @(posedge HCLK); #1;
        present(1'b0, 32'h8, 3'd2, 2'd2);
        bus.HSEL = 1'b0;
        @(negedge HCLK);
        chk("idle_hready", bus.HREADY, 1);
        chk("idle_hresp", bus.HRESP, 0);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        chk("nosel_hready", bus.HREADY, 1);
        chk("nosel_hrdata", bus.HRDATA, 32'hA5A5_A5A5);
        @(posedge HCLK); #1;

        bus0.HSEL   = 1'b1;
        bus0.HTRANS = 2'd2;
        bus0.HADDR  = 32'h4;
        bus0.HWRITE = 1'b1;
        bus0.HSIZE  = 3'd2;
        @(posedge HCLK); #1;
        bus0.HWDATA = 32'hFEDC_AB98;
        bus0.HWRITE = 1'b0;
        @(negedge HCLK);
        chk("fwd_wr_hready", bus0.HREADY, 1);
        @(posedge HCLK); #1;
        bus0.HSEL   = 1'b0;
        bus0.HTRANS = 2'd0;
        @(negedge HCLK);
        chk("fwd_rd_hready", bus0.HREADY, 1);
        chk("fwd_rd_data", bus0.HRDATA, 32'hFEDC_AB98);
        chk("fwd_rd_resp", bus0.HRESP, 0);
        @(posedge HCLK); #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
